branch_predict_controller: RTL and testbench

//  Sequences the branch predictor's redirect outputs. Issues a 1-cycle preload (fetch to predicted

---
 rtl/branch_predict_controller.sv | 155 +++++++++++++++
 tb/tb_branch_predict_controller.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_controller.sv
// Purpose : sequences predictor redirects; in-order checkpoint queue of predicted branches, preload on taken, restore on mispredict.
// Latency : preload/restore/jump_addr are registered, 1 cycle after the triggering predict/resolve edge.
// Backpr. : stall_predict=1 when the queue holds DEPTH entries; a predict_valid seen while stalled is dropped.
// Ports   : clock, reset (async, active-high)
//           predict_valid/predict_taken/predict_target/fallthrough_addr : new prediction from predictor
//           resolve_valid/resolve_taken/resolve_target                   : execute-stage resolution of oldest branch
//           stall_predict, jump_addr, preload, restore, outstanding, resolve_err : status and redirect outputs
module branch_predict_controller #(
  parameter int ADDR_W = 11,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              predict_valid,
  input  logic              predict_taken,
  input  logic [ADDR_W-1:0] predict_target,
  input  logic [ADDR_W-1:0] fallthrough_addr,
  input  logic              resolve_valid,
  input  logic              resolve_taken,
  input  logic [ADDR_W-1:0] resolve_target,
  output logic              stall_predict,
  output logic [ADDR_W-1:0] jump_addr,
  output logic              preload,
  output logic              restore,
  output logic [PTR_W:0]    outstanding,
  output logic              resolve_err
);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  typedef struct packed {
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;
    logic [ADDR_W-1:0] fallthrough;
  } entry_t;

  localparam logic [PTR_W:0]   FULL_CNT = DEPTH[PTR_W:0];
  localparam logic [PTR_W:0]   CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};

  state_t                  state_q, state_d;
  entry_t [DEPTH-1:0]      mem_q, mem_d;
  logic   [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic   [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic   [PTR_W:0]        count_q, count_d;
  logic   [ADDR_W-1:0]     jump_addr_q, jump_addr_d;
  logic                    preload_q, preload_d;
  logic                    restore_q, restore_d;
  logic                    resolve_err_q, resolve_err_d;

  logic   full;
  logic   push;
  logic   pop;
  logic   mispredict;
  entry_t oldest;

  // Full is judged on the registered count so a same-cycle pop never frees space.
  assign full   = (count_q == FULL_CNT);
  assign oldest = mem_q[rd_ptr_q];

  always_comb begin
    state_d       = state_q;
    mem_d         = mem_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    jump_addr_d   = jump_addr_q;
    preload_d     = 1'b0;
    restore_d     = 1'b0;
    resolve_err_d = resolve_err_q;
    push          = 1'b0;
    pop           = 1'b0;
    mispredict    = 1'b0;

    case (state_q)
      RUN: begin
        push = predict_valid && !full;
        pop  = resolve_valid && (count_q != '0);
        if (resolve_valid && (count_q == '0)) begin
          resolve_err_d = 1'b1;
        end
        // Direction mismatch, or both taken but to different targets.
        mispredict = pop &&
                     ((resolve_taken != oldest.pred_taken) ||
                      (resolve_taken && (resolve_target != oldest.pred_target)));

        if (mispredict) begin
          // Restore wins over any same-cycle push; all speculation is dropped.
          restore_d   = 1'b1;
          jump_addr_d = resolve_taken ? resolve_target : oldest.fallthrough;
          count_d     = '0;
          rd_ptr_d    = wr_ptr_q;
          state_d     = FLUSH;
        end else begin
          if (push) begin
            mem_d[wr_ptr_q] = '{pred_taken:  predict_taken,
                                pred_target: predict_target,
                                fallthrough: fallthrough_addr};
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (predict_taken) begin
              preload_d   = 1'b1;
              jump_addr_d = predict_target;
            end
          end
          if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
          end
          case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
          endcase
        end
      end
      FLUSH: begin
        // Wrong-path predict/resolve traffic is ignored for this one cycle.
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= RUN;
      mem_q         <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      jump_addr_q   <= '0;
      preload_q     <= 1'b0;
      restore_q     <= 1'b0;
      resolve_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_q         <= mem_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      jump_addr_q   <= jump_addr_d;
      preload_q     <= preload_d;
      restore_q     <= restore_d;
      resolve_err_q <= resolve_err_d;
    end
  end

  assign stall_predict = full;
  assign jump_addr     = jump_addr_q;
  assign preload       = preload_q;
  assign restore       = restore_q;
  assign outstanding   = count_q;
  assign resolve_err   = resolve_err_q;

endmodule

// File: tb/tb_branch_predict_controller.sv
module tb_branch_predict_controller;

  logic        clock;
  logic        reset;
  logic        predict_valid;
  logic        predict_taken;
  logic [10:0] predict_target;
  logic [10:0] fallthrough_addr;
  logic        resolve_valid;
  logic        resolve_taken;
  logic [10:0] resolve_target;
  logic        stall_predict;
  logic [10:0] jump_addr;
  logic        preload;
  logic        restore;
  logic [2:0]  outstanding;
  logic        resolve_err;

  int checks = 0;
  int errors = 0;

  branch_predict_controller #(.ADDR_W(11), .DEPTH(4), .PTR_W(2)) dut (
    .clock           (clock),
    .reset           (reset),
    .predict_valid   (predict_valid),
    .predict_taken   (predict_taken),
    .predict_target  (predict_target),
    .fallthrough_addr(fallthrough_addr),
    .resolve_valid   (resolve_valid),
    .resolve_taken   (resolve_taken),
    .resolve_target  (resolve_target),
    .stall_predict   (stall_predict),
    .jump_addr       (jump_addr),
    .preload         (preload),
    .restore         (restore),
    .outstanding     (outstanding),
    .resolve_err     (resolve_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        pv;
    logic        pt;
    logic [10:0] ptgt;
    logic [10:0] pft;
    logic        rv;
    logic        rt;
    logic [10:0] rtgt;
    logic        e_pre;
    logic        e_res;
    logic [10:0] e_jmp;
    logic [2:0]  e_out;
    logic        e_stall;
    logic        e_err;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (step %0d): got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input logic e_pre, input logic e_res, input logic [10:0] e_jmp,
                         input logic [2:0] e_out, input logic e_stall, input logic e_err);
    chk("preload",       idx, 32'(preload),       32'(e_pre));
    chk("restore",       idx, 32'(restore),       32'(e_res));
    chk("jump_addr",     idx, 32'(jump_addr),     32'(e_jmp));
    chk("outstanding",   idx, 32'(outstanding),   32'(e_out));
    chk("stall_predict", idx, 32'(stall_predict), 32'(e_stall));
    chk("resolve_err",   idx, 32'(resolve_err),   32'(e_err));
  endtask

  task automatic drive_idle();
    predict_valid    = 1'b0;
    predict_taken    = 1'b0;
    predict_target   = '0;
    fallthrough_addr = '0;
    resolve_valid    = 1'b0;
    resolve_taken    = 1'b0;
    resolve_target   = '0;
  endtask

  // pv pt ptgt pft | rv rt rtgt | pre res jmp out stall err
  task automatic add(input logic pv, input logic pt, input logic [10:0] ptgt, input logic [10:0] pft,
                     input logic rv, input logic rt, input logic [10:0] rtgt,
                     input logic e_pre, input logic e_res, input logic [10:0] e_jmp,
                     input logic [2:0] e_out, input logic e_stall, input logic e_err);
    vec_t v;
    v = '{pv, pt, ptgt, pft, rv, rt, rtgt, e_pre, e_res, e_jmp, e_out, e_stall, e_err};
    vq.push_back(v);
  endtask

  initial begin
    // Basic taken predict + correct resolve
    add(1,1,11'h155,11'h100, 0,0,11'h000, 1,0,11'h155,3'd1,0,0);
    add(0,0,11'h000,11'h000, 0,0,11'h000, 0,0,11'h155,3'd1,0,0);
    add(0,0,11'h000,11'h000, 1,1,11'h155, 0,0,11'h155,3'd0,0,0);
    // Not-taken predicted, actually taken -> restore to resolve target; FLUSH ignores traffic
    add(1,0,11'h200,11'h011, 0,0,11'h000, 0,0,11'h155,3'd1,0,0);
    add(0,0,11'h000,11'h000, 1,1,11'h200, 0,1,11'h200,3'd0,0,0);
    add(1,1,11'h7AA,11'h001, 1,0,11'h000, 0,0,11'h200,3'd0,0,0);
    add(0,0,11'h000,11'h000, 0,0,11'h000, 0,0,11'h200,3'd0,0,0);
    // Fill to DEPTH, drop while full, ordered resolves, pointer wrap
    add(1,1,11'h010,11'h001, 0,0,11'h000, 1,0,11'h010,3'd1,0,0);
    add(1,0,11'h020,11'h002, 0,0,11'h000, 0,0,11'h010,3'd2,0,0);
    add(1,1,11'h030,11'h003, 0,0,11'h000, 1,0,11'h030,3'd3,0,0);
    add(1,0,11'h040,11'h004, 0,0,11'h000, 0,0,11'h030,3'd4,1,0);
    add(1,1,11'h050,11'h005, 0,0,11'h000, 0,0,11'h030,3'd4,1,0);
    add(1,1,11'h060,11'h006, 1,1,11'h010, 0,0,11'h030,3'd3,0,0);
    add(1,1,11'h070,11'h007, 0,0,11'h000, 1,0,11'h070,3'd4,1,0);
    add(0,0,11'h000,11'h000, 1,0,11'h3FF, 0,0,11'h070,3'd3,0,0);
    add(0,0,11'h000,11'h000, 1,1,11'h030, 0,0,11'h070,3'd2,0,0);
    add(1,1,11'h080,11'h008, 1,0,11'h000, 1,0,11'h080,3'd2,0,0);
    add(0,0,11'h000,11'h000, 1,1,11'h070, 0,0,11'h080,3'd1,0,0);
    add(0,0,11'h000,11'h000, 1,1,11'h081, 0,1,11'h081,3'd0,0,0);
    add(0,0,11'h000,11'h000, 0,0,11'h000, 0,0,11'h081,3'd0,0,0);
    // Taken predicted, actually not taken -> restore to fallthrough
    add(1,1,11'h100,11'h00A, 0,0,11'h000, 1,0,11'h100,3'd1,0,0);
    add(0,0,11'h000,11'h000, 1,0,11'h000, 0,1,11'h00A,3'd0,0,0);
    add(0,0,11'h000,11'h000, 0,0,11'h000, 0,0,11'h00A,3'd0,0,0);
    // Same-cycle taken push and mispredicting resolve
    add(1,1,11'h0AA,11'h0AB, 0,0,11'h000, 1,0,11'h0AA,3'd1,0,0);
    add(1,1,11'h3F0,11'h3F1, 1,1,11'h0BB, 0,1,11'h0BB,3'd0,0,0);
    add(0,0,11'h000,11'h000, 0,0,11'h000, 0,0,11'h0BB,3'd0,0,0);
    add(0,0,11'h000,11'h000, 0,0,11'h000, 0,0,11'h0BB,3'd0,0,0);
    // Resolve on empty queue -> sticky error; push still accepted
    add(0,0,11'h000,11'h000, 1,1,11'h222, 0,0,11'h0BB,3'd0,0,1);
    add(0,0,11'h000,11'h000, 0,0,11'h000, 0,0,11'h0BB,3'd0,0,1);
    add(1,0,11'h111,11'h222, 1,0,11'h000, 0,0,11'h0BB,3'd1,0,1);
    add(0,0,11'h000,11'h000, 1,0,11'h000, 0,0,11'h0BB,3'd0,0,1);

    drive_idle();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk_all(-1, 0, 0, 11'h000, 3'd0, 0, 0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clock);
      predict_valid    = vq[i].pv;
      predict_taken    = vq[i].pt;
      predict_target   = vq[i].ptgt;
      fallthrough_addr = vq[i].pft;
      resolve_valid    = vq[i].rv;
      resolve_taken    = vq[i].rt;
      resolve_target   = vq[i].rtgt;
      @(posedge clock);
      #1;
      chk_all(i, vq[i].e_pre, vq[i].e_res, vq[i].e_jmp, vq[i].e_out, vq[i].e_stall, vq[i].e_err);
    end

    // Async reset mid-cycle with a pending taken prediction: everything clears, no restore afterwards.
    @(negedge clock);
    drive_idle();
    predict_valid  = 1'b1;
    predict_taken  = 1'b1;
    predict_target = 11'h123;
    @(posedge clock);
    #1;
    chk_all(100, 1, 0, 11'h123, 3'd1, 0, 1);
    drive_idle();
    #2;
    reset = 1'b1;
    #1;
    chk_all(101, 0, 0, 11'h000, 3'd0, 0, 0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk_all(102, 0, 0, 11'h000, 3'd0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
